// File: rtl/i2s_tdm_source.sv
// i2s_tdm_source: frame FIFO feeding an I2S / left-justified / right-justified / TDM serial transmitter.
// Build option I2S_TDM_SOURCE_REPEAT_EN: on underrun resend the last popped frame instead of silence.
module i2s_tdm_source #(
  parameter int SAMPLE_BITS = 24,
  parameter int SLOT_BITS   = 32,
  parameter int NUM_CH      = 2,
  parameter int MCLK_DIV    = 4,
  parameter int FIFO_AW     = 2
) (
  input  logic                          i2s_master_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    fmt,
  input  logic [NUM_CH*SAMPLE_BITS-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FIFO_AW:0]              fifo_count,
  output logic                          underrun,
  output logic                          bck,
  output logic                          lrck,
  output logic                          sdata
);
  localparam int FRAME_W = NUM_CH * SAMPLE_BITS;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int MW      = $clog2(MCLK_DIV);
  localparam int PW      = $clog2(SLOT_BITS);
  localparam int SW      = $clog2(NUM_CH);
  localparam int IW      = $clog2(SAMPLE_BITS);
`ifdef I2S_TDM_SOURCE_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  localparam logic [1:0] FMT_LJ = 2'd1;
  localparam logic [1:0] FMT_RJ = 2'd2;

  logic [MW-1:0]      mclk_q, mclk_d;
  logic               bck_q, bck_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic               start_q, ready_en_q;
  logic [1:0]         fmt_q, fmt_d;
  logic               tx_on_q, tx_on_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               lrck_q, lrck_d, sdata_q, sdata_d;
  logic               underrun_q, underrun_d;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FRAME_W-1:0] mem [DEPTH];

  logic fall_tick, last_bit, frame_start, load;
  logic fifo_empty, fifo_full, push, pop;
  logic hit, lrck_bit, sdata_bit;
  logic [IW-1:0] idx;
  logic [SAMPLE_BITS-1:0] ch_sample [NUM_CH];

  assign fall_tick   = (mclk_q == MW'(MCLK_DIV - 1));
  assign last_bit    = (pos_q == PW'(SLOT_BITS - 1)) && (slot_q == SW'(NUM_CH - 1));
  // start_q makes the first cycle out of reset behave as a frame start at b=0
  assign frame_start = start_q | (fall_tick & last_bit);
  assign load        = start_q | fall_tick;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign pop         = frame_start & enable & ~fifo_empty;
  assign in_ready    = ready_en_q & (~fifo_full | pop);
  assign push        = in_valid & in_ready;

  always_comb begin
    mclk_d = fall_tick ? '0 : mclk_q + 1'b1;
    bck_d  = (mclk_d >= MW'(MCLK_DIV / 2));
    pos_d  = pos_q;
    slot_d = slot_q;
    if (start_q) begin
      pos_d  = '0;
      slot_d = '0;
    end else if (fall_tick) begin
      if (pos_q == PW'(SLOT_BITS - 1)) begin
        pos_d  = '0;
        slot_d = last_bit ? '0 : slot_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
    fmt_d      = frame_start ? fmt : fmt_q;
    tx_on_d    = frame_start ? (enable & (~fifo_empty | REPEAT)) : tx_on_q;
    frame_d    = pop ? mem[rd_ptr_q] : frame_q;
    underrun_d = frame_start & enable & fifo_empty;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_sample[gi] = frame_d[(NUM_CH - 1 - gi) * SAMPLE_BITS +: SAMPLE_BITS];
  end

  // Outputs are computed for the bit being entered, so they change with bck falling
  always_comb begin
    hit = 1'b0;
    idx = '0;
    case (fmt_d)
      FMT_LJ: if (pos_d < PW'(SAMPLE_BITS)) begin
        hit = 1'b1;
        idx = IW'(PW'(SAMPLE_BITS - 1) - pos_d);
      end
      FMT_RJ: if (pos_d >= PW'(SLOT_BITS - SAMPLE_BITS)) begin
        hit = 1'b1;
        idx = IW'(PW'(SLOT_BITS - 1) - pos_d);
      end
      default: if (pos_d != '0 && pos_d <= PW'(SAMPLE_BITS)) begin
        hit = 1'b1;
        idx = IW'(PW'(SAMPLE_BITS) - pos_d);
      end
    endcase
    if (NUM_CH > 2) lrck_bit = (slot_d == '0) && (pos_d == '0);
    else if (fmt_d == FMT_LJ || fmt_d == FMT_RJ) lrck_bit = (slot_d == '0);
    else lrck_bit = (slot_d != '0);
    sdata_bit = tx_on_d & hit & ch_sample[slot_d][idx];
    lrck_d    = load ? lrck_bit : lrck_q;
    sdata_d   = load ? sdata_bit : sdata_q;
  end

  always_ff @(posedge i2s_master_clk or posedge reset) begin
    if (reset) begin
      mclk_q     <= '0;
      bck_q      <= 1'b0;
      pos_q      <= '0;
      slot_q     <= '0;
      start_q    <= 1'b1;
      ready_en_q <= 1'b0;
      fmt_q      <= '0;
      tx_on_q    <= 1'b0;
      frame_q    <= '0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mclk_q     <= mclk_d;
      bck_q      <= bck_d;
      pos_q      <= pos_d;
      slot_q     <= slot_d;
      start_q    <= 1'b0;
      ready_en_q <= 1'b1;
      fmt_q      <= fmt_d;
      tx_on_q    <= tx_on_d;
      frame_q    <= frame_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i2s_master_clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign fifo_count = count_q;
  assign underrun   = underrun_q;
  assign bck        = bck_q;
  assign lrck       = lrck_q;
  assign sdata      = sdata_q;
endmodule

// File: tb/tb_i2s_tdm_source.sv
// Directed bench for i2s_tdm_source: a stereo instance (all formats, FIFO, underrun, reset)
// and an 8-channel TDM instance sharing clock and reset.
module tb_i2s_tdm_source;
  logic clk, reset;
  logic enable, in_valid, in_ready, underrun, bck, lrck, sdata;
  logic [1:0] fmt;
  logic [47:0] in_data;
  logic [2:0] fifo_count;
  logic en8, valid8, ready8, underrun8, bck8, lrck8, sdata8;
  logic [1:0] fmt8;
  logic [191:0] data8;
  logic [2:0] count8;

  int cyc, n_pass, n_total, mon_g;
  logic [63:0]  sh_sd, sh_lr, cap_sd [0:15], cap_lr [0:15];
  logic [255:0] sh8_sd, sh8_lr, cap8_sd [0:3], cap8_lr [0:3];
  logic [255:0] exp8;
  logic [63:0]  exp_ur;
  logic [47:0]  g_frames [0:4];

  i2s_tdm_source dut (
    .i2s_master_clk(clk), .reset(reset), .enable(enable), .fmt(fmt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fifo_count(fifo_count), .underrun(underrun),
    .bck(bck), .lrck(lrck), .sdata(sdata)
  );

  i2s_tdm_source #(.NUM_CH(8)) dut8 (
    .i2s_master_clk(clk), .reset(reset), .enable(en8), .fmt(fmt8),
    .in_data(data8), .in_valid(valid8), .in_ready(ready8),
    .fifo_count(count8), .underrun(underrun8),
    .bck(bck8), .lrck(lrck8), .sdata(sdata8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Sample every serial bit mid-period (bck high) and store whole frames
  always @(negedge clk) begin
    if (!reset && cyc >= 2 && cyc % 4 == 2) begin
      mon_g  = (cyc - 2) / 4;
      sh_sd  = {sh_sd[62:0], sdata};
      sh_lr  = {sh_lr[62:0], lrck};
      sh8_sd = {sh8_sd[254:0], sdata8};
      sh8_lr = {sh8_lr[254:0], lrck8};
      if (mon_g % 64 == 63 && mon_g / 64 < 16) begin
        cap_sd[4'(mon_g / 64)] = sh_sd;
        cap_lr[4'(mon_g / 64)] = sh_lr;
      end
      if (mon_g % 256 == 255 && mon_g / 256 < 4) begin
        cap8_sd[2'(mon_g / 256)] = sh8_sd;
        cap8_lr[2'(mon_g / 256)] = sh8_lr;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input logic [47:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int acc_cyc;
    n_pass = 0; n_total = 0;
    reset = 1'b1; enable = 1'b1; fmt = 2'd0; in_valid = 1'b0; in_data = '0;
    en8 = 1'b1; fmt8 = 2'd0; valid8 = 1'b0; data8 = '0;
    g_frames[0] = {24'h123456, 24'hFEDCBA};
    g_frames[1] = {24'h111111, 24'h222222};
    g_frames[2] = {24'h333333, 24'h444444};
    g_frames[3] = {24'h555555, 24'h666666};
    g_frames[4] = {24'h89ABCD, 24'h010203};
    repeat (3) @(negedge clk);
    chk("rst_bck", bck, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_underrun", underrun, 0);
    reset = 1'b0;

    wait_cyc(1);
    chk("start_underrun", underrun, 1);
    chk("start_in_ready", in_ready, 1);
    wait_cyc(2);
    chk("start_underrun_clear", underrun, 0);
    wait_cyc(10);
    push({24'hA5A5A5, 24'h5A5A5A});
    chk("count_after_push", fifo_count, 1);
    wait_cyc(12);
    exp8 = '0;
    for (int n = 0; n < 8; n++) begin
      data8 = {data8[167:0], 24'hC00000 + 24'(n)};
      exp8  = {exp8[223:0], 1'b0, 24'hC00000 + 24'(n), 7'd0};
    end
    valid8 = 1'b1;
    @(negedge clk);
    valid8 = 1'b0;
    chk("tdm_count_after_push", count8, 1);

    wait_cyc(256);
    chk("f1_popped_count", fifo_count, 0);
    chk("f1_no_underrun", underrun, 0);
    wait_cyc(300);
    fmt = 2'd1;
    push({24'hA5A5A5, 24'h5A5A5A});
    wait_cyc(600);
    fmt = 2'd2;
    push({24'hA5A5A5, 24'h5A5A5A});
    wait_cyc(1000);
    fmt = 2'd0;
    wait_cyc(1024);
    chk("f4_underrun", underrun, 1);
    wait_cyc(1025);
    chk("f4_underrun_clear", underrun, 0);
    chk("f0_silence", cap_sd[0], 64'd0);
    chk("f0_lrck_i2s", cap_lr[0], {32'h0, 32'hFFFFFFFF});
    chk("f1_i2s_data", cap_sd[1], {1'b0, 24'hA5A5A5, 7'd0, 1'b0, 24'h5A5A5A, 7'd0});
    chk("f1_i2s_lrck", cap_lr[1], {32'h0, 32'hFFFFFFFF});
    chk("f2_lj_data", cap_sd[2], {24'hA5A5A5, 8'd0, 24'h5A5A5A, 8'd0});
    chk("f2_lj_lrck", cap_lr[2], {32'hFFFFFFFF, 32'h0});
    chk("f3_rj_data", cap_sd[3], {8'd0, 24'hA5A5A5, 8'd0, 24'h5A5A5A});
    chk("f3_rj_lrck", cap_lr[3], {32'hFFFFFFFF, 32'h0});
    chk("tdm_f0_lrck", cap8_lr[0], {1'b1, 255'd0});

    wait_cyc(1030);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = g_frames[i];
      @(negedge clk);
    end
    in_data = g_frames[4];
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    acc_cyc = 0;
    while (!in_ready && cyc < 1400) @(negedge clk);
    acc_cyc = cyc;
    chk("fifth_accept_cycle", 32'(acc_cyc), 32'd1279);
    @(negedge clk);
    in_valid = 1'b0;
    chk("count_push_pop", fifo_count, 4);
    chk("f5_no_underrun", underrun, 0);

    wait_cyc(2560);
    chk("f10_underrun", underrun, 1);
    wait_cyc(2561);
    chk("f10_underrun_clear", underrun, 0);
    wait_cyc(2816);
    chk("f11_underrun", underrun, 1);
    wait_cyc(2900);
    enable = 1'b0;
    wait_cyc(3072);
    chk("f12_disabled_no_underrun", underrun, 0);
    wait_cyc(3330);
    chk("f5_data", cap_sd[5], {1'b0, 24'h123456, 7'd0, 1'b0, 24'hFEDCBA, 7'd0});
    chk("f9_data", cap_sd[9], {1'b0, 24'h89ABCD, 7'd0, 1'b0, 24'h010203, 7'd0});
`ifdef I2S_TDM_SOURCE_REPEAT_EN
    exp_ur = {1'b0, 24'h89ABCD, 7'd0, 1'b0, 24'h010203, 7'd0};
`else
    exp_ur = 64'd0;
`endif
    chk("f10_underrun_data", cap_sd[10], exp_ur);
    chk("f11_underrun_data", cap_sd[11], exp_ur);
    chk("f12_disabled_data", cap_sd[12], 64'd0);
    chk("f12_disabled_lrck", cap_lr[12], {32'h0, 32'hFFFFFFFF});
    chk("tdm_f1_data", cap8_sd[1], exp8);
    chk("tdm_f1_lrck", cap8_lr[1], {1'b1, 255'd0});
    chk("tdm_f2_lrck", cap8_lr[2], {1'b1, 255'd0});

    wait_cyc(3340);
    push(g_frames[1]);
    push(g_frames[2]);
    push(g_frames[3]);
    chk("queued_count", fifo_count, 3);
    wait_cyc(3498);
    chk("pre_reset_bck", bck, 1);
    chk("pre_reset_lrck", lrck, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_bck", bck, 0);
    chk("midrst_lrck", lrck, 0);
    chk("midrst_sdata", sdata, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    reset  = 1'b0;
    wait_cyc(1);
    chk("post_rst_underrun", underrun, 1);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_count", fifo_count, 0);
    for (int c = 2; c < 10; c++) begin
      wait_cyc(c);
      chk($sformatf("bck_c%0d", c), bck, ((c % 4) >= 2) ? 1 : 0);
    end
    wait_cyc(256);
    chk("post_rst_f1_underrun", underrun, 1);
    chk("post_rst_f1_count", fifo_count, 0);
    wait_cyc(258);
    chk("post_rst_f0_silence", cap_sd[0], 64'd0);
    chk("post_rst_f0_lrck", cap_lr[0], {32'h0, 32'hFFFFFFFF});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
